// File: rtl/spi_tx_arbiter.sv
// Round-robin arbiter sharing one spi_generator between NUM_REQ requesters.
// Frames each word with an active-low chip select with setup, hold and gap timing.
module spi_tx_arbiter #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned CS_SETUP   = 2,
   parameter int unsigned CS_HOLD    = 2,
   parameter int unsigned GAP_CYCLES = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            grant,
   output logic [NUM_REQ-1:0]            done,
   output logic [DATA_WIDTH-1:0]         spi_data,
   output logic                          spi_strobe,
   input  logic                          spi_busy,
   output logic                          spi_cs_n,
   output logic                          active,
   output logic [$clog2(NUM_REQ)-1:0]    active_id
);

   localparam int unsigned IdW    = $clog2(NUM_REQ);
   localparam int unsigned MaxSh  = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
   localparam int unsigned MaxCnt = (MaxSh > GAP_CYCLES) ? MaxSh : GAP_CYCLES;
   localparam int unsigned CntW   = $clog2(MaxCnt + 1);

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StStart,
      StWaitBusy,
      StShift,
      StHold,
      StGap
   } state_e;

   state_e                state_q, state_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic [IdW-1:0]        ptr_q, ptr_d;
   logic [NUM_REQ-1:0]    grant_q, grant_d;
   logic [NUM_REQ-1:0]    done_q, done_d;
   logic [DATA_WIDTH-1:0] spi_data_q, spi_data_d;
   logic                  strobe_q, strobe_d;
   logic                  cs_n_q, cs_n_d;
   logic                  active_q, active_d;
   logic [IdW-1:0]        active_id_q, active_id_d;

   logic                  sel_found;
   logic [IdW-1:0]        sel_idx;

   // Search starts just after the last owner, so it gets lowest priority.
   always_comb begin : arb
      int unsigned cand;
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = 0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         cand = (int'(ptr_q) + i) % NUM_REQ;
         if (!sel_found && req[cand]) begin
            sel_found = 1'b1;
            sel_idx   = IdW'(cand);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
      ptr_d       = ptr_q;
      grant_d     = '0;
      done_d      = '0;
      spi_data_d  = spi_data_q;
      strobe_d    = 1'b0;
      cs_n_d      = cs_n_q;
      active_id_d = active_id_q;

      unique case (state_q)
         StIdle: begin
            if (sel_found) begin
               state_d          = StSetup;
               grant_d[sel_idx] = 1'b1;
               spi_data_d       = req_data[sel_idx*DATA_WIDTH +: DATA_WIDTH];
               active_id_d      = sel_idx;
               ptr_d            = sel_idx;
               cs_n_d           = 1'b0;
               cnt_d            = CntW'(CS_SETUP - 1);
            end
         end
         StSetup: begin
            if (cnt_q == '0) begin
               state_d  = StStart;
               strobe_d = 1'b1;
            end
         end
         StStart: state_d = StWaitBusy;
         StWaitBusy: begin
            if (spi_busy) state_d = StShift;
         end
         StShift: begin
            if (!spi_busy) begin
               state_d = StHold;
               cnt_d   = CntW'(CS_HOLD - 1);
            end
         end
         StHold: begin
            if (cnt_q == '0) begin
               state_d = StGap;
               cs_n_d  = 1'b1;
               cnt_d   = CntW'(GAP_CYCLES - 1);
            end
         end
         StGap: begin
            if (cnt_q == '0) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // done is registered, so raise it on entry to the final HOLD cycle.
      if (state_d == StHold && cnt_d == '0) done_d[active_id_q] = 1'b1;

      active_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         ptr_q       <= IdW'(NUM_REQ - 1);
         grant_q     <= '0;
         done_q      <= '0;
         spi_data_q  <= '0;
         strobe_q    <= 1'b0;
         cs_n_q      <= 1'b1;
         active_q    <= 1'b0;
         active_id_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ptr_q       <= ptr_d;
         grant_q     <= grant_d;
         done_q      <= done_d;
         spi_data_q  <= spi_data_d;
         strobe_q    <= strobe_d;
         cs_n_q      <= cs_n_d;
         active_q    <= active_d;
         active_id_q <= active_id_d;
      end
   end

   assign grant      = grant_q;
   assign done       = done_q;
   assign spi_data   = spi_data_q;
   assign spi_strobe = strobe_q;
   assign spi_cs_n   = cs_n_q;
   assign active     = active_q;
   assign active_id  = active_id_q;

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Scoreboard bench for spi_tx_arbiter: stimulus queues expected frames, a negedge
// monitor pops them on each grant and checks framing, timing and completion.
module tb_spi_tx_arbiter;

   localparam int NUM_REQ    = 4;
   localparam int DW         = 16;
   localparam int CS_SETUP   = 2;
   localparam int CS_HOLD    = 2;
   localparam int GAP_CYCLES = 4;
   localparam int BUSY_LEN   = 5;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b1;
   logic [NUM_REQ-1:0]    req = '0;
   logic [NUM_REQ*DW-1:0] req_data = '0;
   logic [NUM_REQ-1:0]    grant, done;
   logic [DW-1:0]         spi_data;
   logic                  spi_strobe;
   logic                  spi_busy = 1'b0;
   logic                  spi_cs_n, active;
   logic [1:0]            active_id;

   spi_tx_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .DATA_WIDTH(DW),
      .CS_SETUP  (CS_SETUP),
      .CS_HOLD   (CS_HOLD),
      .GAP_CYCLES(GAP_CYCLES)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .req_data  (req_data),
      .grant     (grant),
      .done      (done),
      .spi_data  (spi_data),
      .spi_strobe(spi_strobe),
      .spi_busy  (spi_busy),
      .spi_cs_n  (spi_cs_n),
      .active    (active),
      .active_id (active_id)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          id;
      logic [DW-1:0] data;
   } frame_t;

   frame_t exp_q[$];
   frame_t f;
   int n_vec = 0, n_err = 0;
   int n_grants = 0, n_dones = 0, cyc = 0, gap_seen = 0;
   bit gap_check = 1'b0;

   // Monitor state for the frame in flight
   bit cur_valid = 1'b0, seen_strobe = 1'b0, frame_bad = 1'b0, prev_busy = 1'b0;
   int cur_id = 0, setup_cnt = 0, strobes = 0, fall_cyc = 0, hi_run = 0;
   logic [DW-1:0] cur_data = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic flag_fail(input string name, input string what);
      n_vec++;
      n_err++;
      $display("FAIL %s: %s", name, what);
   endtask

   function automatic int oh2id(input logic [NUM_REQ-1:0] v);
      int r = -1;
      for (int i = 0; i < NUM_REQ; i++) if (v[i]) r = i;
      return r;
   endfunction

   // spi_generator stand-in: busy rises the cycle after the strobe for BUSY_LEN cycles.
   initial begin : busy_model
      bit st;
      int bcnt = 0;
      forever begin
         @(negedge clk);
         st = spi_strobe;
         @(posedge clk);
         #1;
         if (!rst_n) begin
            spi_busy = 1'b0;
            bcnt     = 0;
         end else if (st) begin
            spi_busy = 1'b1;
            bcnt     = BUSY_LEN;
         end else if (bcnt > 0) begin
            bcnt--;
            spi_busy = (bcnt != 0);
         end
      end
   end

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         cur_valid = 1'b0;
         prev_busy = 1'b0;
         hi_run    = 0;
      end else begin
         if (grant != '0) begin
            n_grants++;
            check("grant_onehot", 64'($onehot(grant)), 1);
            if (exp_q.size() == 0) begin
               flag_fail("unexpected_grant", $sformatf("got grant=%b, expected none", grant));
            end else begin
               f = exp_q.pop_front();
               check("grant_id", 64'(oh2id(grant)), 64'(f.id));
               check("grant_data", 64'(spi_data), 64'(f.data));
               check("grant_active_id", 64'(active_id), 64'(f.id));
               cur_valid   = 1'b1;
               cur_id      = f.id;
               cur_data    = f.data;
               setup_cnt   = 0;
               strobes     = 0;
               seen_strobe = 1'b0;
               frame_bad   = 1'b0;
            end
         end
         if (cur_valid) begin
            if (spi_data !== cur_data || active !== 1'b1 || spi_cs_n !== 1'b0) frame_bad = 1'b1;
            if (spi_strobe) begin
               strobes++;
               if (!seen_strobe) check("setup_cycles", 64'(setup_cnt), 64'(CS_SETUP));
               seen_strobe = 1'b1;
            end else if (!seen_strobe) begin
               setup_cnt++;
            end
         end
         if (prev_busy && !spi_busy) fall_cyc = cyc;
         prev_busy = spi_busy;
         if (done != '0) begin
            n_dones++;
            if (!cur_valid) begin
               flag_fail("unexpected_done", $sformatf("got done=%b, expected none", done));
            end else begin
               check("done_onehot", 64'($onehot(done)), 1);
               check("done_id", 64'(oh2id(done)), 64'(cur_id));
               check("strobes_per_frame", 64'(strobes), 1);
               check("frame_stable", 64'(frame_bad), 0);
               check("hold_cycles", 64'(cyc - fall_cyc), 64'(CS_HOLD));
               cur_valid = 1'b0;
            end
         end
         if (spi_cs_n) begin
            hi_run++;
         end else begin
            if (hi_run > 0 && gap_check) begin
               gap_seen++;
               check("gap_cycles", 64'(hi_run), 64'(GAP_CYCLES + 1));
            end
            hi_run = 0;
         end
      end
   end

   task automatic push(input int id, input logic [DW-1:0] d);
      frame_t e;
      e.id   = id;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic set_slot(input int i, input logic [DW-1:0] d);
      req_data[i*DW +: DW] = d;
   endtask

   task automatic wait_grants(input int n);
      int t = 0;
      while (n_grants < n && t < 2000) begin
         @(posedge clk);
         t++;
      end
      #1;
      if (n_grants < n) flag_fail("grant_timeout", $sformatf("got %0d grants, expected %0d", n_grants, n));
   endtask

   task automatic wait_dones(input int n);
      int t = 0;
      while (n_dones < n && t < 2000) begin
         @(posedge clk);
         t++;
      end
      #1;
      if (n_dones < n) flag_fail("done_timeout", $sformatf("got %0d dones, expected %0d", n_dones, n));
   endtask

   task automatic wait_busy();
      int t = 0;
      while (spi_busy !== 1'b1 && t < 200) begin
         @(posedge clk);
         t++;
      end
      #1;
      if (spi_busy !== 1'b1) flag_fail("busy_timeout", "got busy=0, expected busy=1");
   endtask

   initial begin
      // Reset state
      #2 rst_n = 1'b0;
      #1;
      check("rst_cs_n", 64'(spi_cs_n), 1);
      check("rst_grant", 64'(grant), 0);
      check("rst_done", 64'(done), 0);
      check("rst_strobe", 64'(spi_strobe), 0);
      check("rst_active", 64'(active), 0);
      check("rst_spi_data", 64'(spi_data), 0);
      check("rst_active_id", 64'(active_id), 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Contention from reset: order 0,1,2,3,0,1,2,3
      for (int i = 0; i < NUM_REQ; i++) set_slot(i, DW'(16'h1111 * (i + 1)));
      for (int k = 0; k < 8; k++) push(k % NUM_REQ, DW'(16'h1111 * ((k % NUM_REQ) + 1)));
      req = 4'b1111;
      wait_grants(8);
      req = '0;
      wait_dones(8);

      // Single requester
      set_slot(2, 16'hA5C3);
      push(2, 16'hA5C3);
      req = 4'b0100;
      wait_grants(9);
      req = '0;
      wait_dones(9);

      // Back-to-back frames from req[1]; measure cs_n high time between them
      set_slot(1, 16'hBEEF);
      push(1, 16'hBEEF);
      push(1, 16'hCAFE);
      req = 4'b0010;
      wait_grants(10);
      set_slot(1, 16'hCAFE);
      gap_check = 1'b1;
      wait_grants(11);
      gap_check = 1'b0;
      req = '0;
      wait_dones(11);
      check("gap_measured", 64'(gap_seen), 1);

      // Rotation from ptr=1 with req=1001: 3 then 0
      set_slot(0, 16'h0F0F);
      set_slot(3, 16'h3C3C);
      push(3, 16'h3C3C);
      push(0, 16'h0F0F);
      req = 4'b1001;
      wait_grants(13);
      req = '0;
      wait_dones(13);

      // Withdrawn request during an active frame is never granted
      set_slot(2, 16'h5A5A);
      push(2, 16'h5A5A);
      req = 4'b0100;
      wait_grants(14);
      req = '0;
      wait_busy();
      req = 4'b0010;
      @(posedge clk);
      #1 req = '0;
      wait_dones(14);
      repeat (20) @(posedge clk);
      #1;
      check("withdraw_grants", 64'(n_grants), 14);
      check("withdraw_dones", 64'(n_dones), 14);

      // Reset mid-SHIFT aborts the frame without done
      set_slot(3, 16'h7E7E);
      push(3, 16'h7E7E);
      req = 4'b1000;
      wait_grants(15);
      req = '0;
      wait_busy();
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("abort_cs_n", 64'(spi_cs_n), 1);
      check("abort_active", 64'(active), 0);
      check("abort_strobe", 64'(spi_strobe), 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("abort_no_done", 64'(n_dones), 14);

      // After reset req[0] wins over req[3]
      set_slot(0, 16'h1234);
      push(0, 16'h1234);
      req = 4'b1001;
      wait_grants(16);
      req = '0;
      wait_dones(15);

      repeat (20) @(posedge clk);
      #1;
      check("exp_queue_empty", 64'(exp_q.size()), 0);
      check("total_grants", 64'(n_grants), 16);
      check("total_dones", 64'(n_dones), 15);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no end of test, expected completion");
      $fatal(1);
   end

endmodule
